// File: rtl/core_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset fetch address, sequential-PC helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_VALID = 2'd3
  } fetch_state_e;

  // Next sequential fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch bundle: imem request/response channel plus the instruction hand-off to decode.
// Latency: n/a (wires only).
// Backpressure: imem_req_ready stalls requests, inst_ready stalls instruction delivery.
// Ports: master = fetch controller side, slave = memory/decode side.
interface fetch_ctrl_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/redirect_sel.sv
// Redirect priority mux: jump beats trap entry, trap entry beats trap return.
// Latency: combinational.
// Backpressure: none.
// Ports: jump/csr_ecall/csr_mret requests with their targets in; redir_valid + redir_target out.
module redirect_sel (
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        csr_ecall,
  input  logic [31:0] csr_mtvec,
  input  logic        csr_mret,
  input  logic [31:0] csr_mepc,
  output logic        redir_valid,
  output logic [31:0] redir_target
);

  always_comb begin
    redir_valid  = jump | csr_ecall | csr_mret;
    redir_target = csr_mepc;
    if (jump)           redir_target = jump_addr;
    else if (csr_ecall) redir_target = csr_mtvec;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect with stale-response drop.
// Latency: request accepted cycle N, response N+1, inst_valid N+2.
// Backpressure: holds request until imem_req_ready; holds inst/inst_pc until inst_ready.
// Ports: clk/rst, redirect requests (jump, csr_ecall, csr_mret + targets), bus (fetch_ctrl_if.master).
module fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         jump,
  input  logic [31:0]  jump_addr,
  input  logic         csr_ecall,
  input  logic [31:0]  csr_mtvec,
  input  logic         csr_mret,
  input  logic [31:0]  csr_mepc,
  fetch_ctrl_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         redir_valid;
  logic [31:0]  redir_target;
  logic         req_valid;
  logic         out_valid;

  redirect_sel u_redirect_sel (
    .jump         (jump),
    .jump_addr    (jump_addr),
    .csr_ecall    (csr_ecall),
    .csr_mtvec    (csr_mtvec),
    .csr_mret     (csr_mret),
    .csr_mepc     (csr_mepc),
    .redir_valid  (redir_valid),
    .redir_target (redir_target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    req_valid = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        req_valid = 1'b1;
        if (redir_valid) pc_d = redir_target;
        if (bus.imem_req_ready) begin
          state_d = ST_WAIT;
          // Request already left for the old pc: its response must be thrown away.
          if (redir_valid) drop_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (redir_valid) begin
          pc_d = redir_target;
          // A response in the same cycle retires the outstanding request, so nothing is left to drop.
          drop_d = ~bus.imem_resp_valid;
          if (bus.imem_resp_valid) state_d = ST_REQ;
        end else if (bus.imem_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            inst_d    = bus.imem_resp_data;
            inst_pc_d = pc_q;
            state_d   = ST_VALID;
          end
        end
      end

      ST_VALID: begin
        out_valid = 1'b1;
        if (redir_valid) begin
          pc_d    = redir_target;
          state_d = ST_REQ;
        end else if (bus.inst_ready) begin
          pc_d    = seq_pc(inst_pc_q);
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = out_valid;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        jump;
  logic [31:0] jump_addr;
  logic        csr_ecall;
  logic [31:0] csr_mtvec;
  logic        csr_mret;
  logic [31:0] csr_mepc;
  int          errors;
  int          checks;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(32'h8000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .jump      (jump),
    .jump_addr (jump_addr),
    .csr_ecall (csr_ecall),
    .csr_mtvec (csr_mtvec),
    .csr_mret  (csr_mret),
    .csr_mepc  (csr_mepc),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    jump = 0; jump_addr = '0; csr_ecall = 0; csr_mtvec = '0; csr_mret = 0; csr_mepc = '0;
    bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = '0; bus.inst_ready = 0;
  endtask

  // Reset, release, and land in REQ at the reset pc.
  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    step();
  endtask

  // From REQ: accept the request, return data one cycle later; ends in VALID.
  task automatic fetch_one(input logic [31:0] data);
    bus.imem_req_ready = 1;
    step();
    bus.imem_req_ready = 0;
    bus.imem_resp_valid = 1; bus.imem_resp_data = data;
    step();
    bus.imem_resp_valid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    step(); step();
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid); end
    checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 00000000", bus.inst); end
    checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want 00000000", bus.inst_pc); end
    // First cycle out of reset is IDLE; a redirect there must not move the pc.
    rst = 0; jump = 1; jump_addr = 32'h8000_0100;
    step();
    jump = 0;
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL idle_to_req: got %b want 1", bus.imem_req_valid); end
    checks++; if (bus.imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL idle_redirect_ignored: got %h want 80000000", bus.imem_req_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] data_tab [3];
    logic [31:0] addr_tab [3];
    data_tab = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
    addr_tab = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.imem_req_addr !== addr_tab[i]) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", i, bus.imem_req_addr, addr_tab[i]); end
      bus.imem_req_ready = 1;
      step();
      bus.imem_req_ready = 0;
      checks++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL seq_wait[%0d]: got req=%b inst=%b want 0 0", i, bus.imem_req_valid, bus.inst_valid); end
      bus.imem_resp_valid = 1; bus.imem_resp_data = data_tab[i];
      step();
      bus.imem_resp_valid = 0;
      checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL seq_inst_valid[%0d]: got %b want 1", i, bus.inst_valid); end
      checks++; if (bus.inst !== data_tab[i]) begin errors++; $display("FAIL seq_inst[%0d]: got %h want %h", i, bus.inst, data_tab[i]); end
      checks++; if (bus.inst_pc !== addr_tab[i]) begin errors++; $display("FAIL seq_inst_pc[%0d]: got %h want %h", i, bus.inst_pc, addr_tab[i]); end
      bus.inst_ready = 1;
      step();
      bus.inst_ready = 0;
    end
    checks++; if (bus.imem_req_addr !== 32'h8000_000C) begin errors++; $display("FAIL seq_next_addr: got %h want 8000000c", bus.imem_req_addr); end
  endtask

  task automatic test_req_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL stall_hold[%0d]: got v=%b a=%h want 1 80000000", i, bus.imem_req_valid, bus.imem_req_addr); end
      step();
    end
    bus.imem_req_ready = 1;
    step();
    bus.imem_req_ready = 0;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_accept: got %b want 0", bus.imem_req_valid); end
    bus.imem_resp_valid = 1; bus.imem_resp_data = 32'h1234_5678;
    step();
    bus.imem_resp_valid = 0;
    checks++; if (bus.inst_pc !== 32'h8000_0000 || bus.inst !== 32'h1234_5678) begin errors++; $display("FAIL stall_deliver: got pc=%h i=%h want 80000000 12345678", bus.inst_pc, bus.inst); end
  endtask

  task automatic test_jump_wait();
    do_reset();
    bus.imem_req_ready = 1;
    step();
    bus.imem_req_ready = 0;
    jump = 1; jump_addr = 32'h8000_0100;
    step();
    jump = 0;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL jw_still_wait: got %b want 0", bus.imem_req_valid); end
    bus.imem_resp_valid = 1; bus.imem_resp_data = 32'hDEAD_BEEF;
    step();
    bus.imem_resp_valid = 0;
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL jw_discard: got inst_valid=%b want 0", bus.inst_valid); end
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0100) begin errors++; $display("FAIL jw_refetch: got v=%b a=%h want 1 80000100", bus.imem_req_valid, bus.imem_req_addr); end
    fetch_one(32'h1111_2222);
    checks++; if (bus.inst_pc !== 32'h8000_0100 || bus.inst !== 32'h1111_2222) begin errors++; $display("FAIL jw_deliver: got pc=%h i=%h want 80000100 11112222", bus.inst_pc, bus.inst); end
  endtask

  task automatic test_redirect_accept();
    do_reset();
    bus.imem_req_ready = 1; jump = 1; jump_addr = 32'h8000_0100;
    step();
    bus.imem_req_ready = 0; jump = 0;
    bus.imem_resp_valid = 1; bus.imem_resp_data = 32'hBAD0_BAD0;
    step();
    bus.imem_resp_valid = 0;
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0100) begin errors++; $display("FAIL ra_drop: got iv=%b rv=%b a=%h want 0 1 80000100", bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_priority();
    do_reset();
    fetch_one(32'hAAAA_0001);
    csr_mtvec = 32'h8000_0200; csr_mepc = 32'h8000_0300;
    bus.inst_ready = 1; jump = 1; jump_addr = 32'h8000_0100; csr_ecall = 1;
    step();
    bus.inst_ready = 0; jump = 0; csr_ecall = 0;
    checks++; if (bus.imem_req_addr !== 32'h8000_0100) begin errors++; $display("FAIL prio_jump_ecall: got %h want 80000100", bus.imem_req_addr); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL prio_inst_drop: got %b want 0", bus.inst_valid); end
    fetch_one(32'hAAAA_0002);
    bus.inst_ready = 1; csr_ecall = 1; csr_mret = 1;
    step();
    bus.inst_ready = 0; csr_ecall = 0; csr_mret = 0;
    checks++; if (bus.imem_req_addr !== 32'h8000_0200) begin errors++; $display("FAIL prio_ecall_mret: got %h want 80000200", bus.imem_req_addr); end
    fetch_one(32'hAAAA_0003);
    csr_mret = 1;
    step();
    csr_mret = 0;
    checks++; if (bus.imem_req_addr !== 32'h8000_0300 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL prio_mret_nohs: got a=%h iv=%b want 80000300 0", bus.imem_req_addr, bus.inst_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_one(32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'hCAFE_F00D || bus.inst_pc !== 32'h8000_0000 || bus.imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: got iv=%b i=%h pc=%h rv=%b want 1 cafef00d 80000000 0", i, bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req_valid);
      end
      // A stray response while holding an instruction must not disturb it.
      bus.imem_resp_valid = (i == 2); bus.imem_resp_data = 32'h5555_5555;
      step();
    end
    bus.imem_resp_valid = 0;
    bus.inst_ready = 1;
    step();
    bus.inst_ready = 0;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0004) begin errors++; $display("FAIL bp_release: got v=%b a=%h want 1 80000004", bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    jump = 1; jump_addr = 32'hFFFF_FFFC;
    step();
    jump = 0;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req_redirect: got v=%b a=%h want 1 fffffffc", bus.imem_req_valid, bus.imem_req_addr); end
    fetch_one(32'h0BAD_F00D);
    checks++; if (bus.inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_inst_pc: got %h want fffffffc", bus.inst_pc); end
    bus.inst_ready = 1;
    step();
    bus.inst_ready = 0;
    checks++; if (bus.imem_req_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", bus.imem_req_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fetch_one(32'h7777_7777);
    bus.inst_ready = 1;
    step();
    bus.inst_ready = 0;
    bus.imem_req_ready = 1;
    step();
    bus.imem_req_ready = 0;
    rst = 1;
    step();
    checks++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
      errors++; $display("FAIL mid_reset_state: got rv=%b iv=%b i=%h pc=%h want 0 0 0 0", bus.imem_req_valid, bus.inst_valid, bus.inst, bus.inst_pc);
    end
    rst = 0;
    bus.imem_resp_valid = 1; bus.imem_resp_data = 32'hBBBB_BBBB;
    step();
    bus.imem_resp_valid = 0;
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0000) begin
      errors++; $display("FAIL mid_reset_restart: got iv=%b rv=%b a=%h want 0 1 80000000", bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr);
    end
    fetch_one(32'h0000_0013);
    checks++; if (bus.inst !== 32'h0000_0013 || bus.inst_pc !== 32'h8000_0000) begin errors++; $display("FAIL mid_reset_fetch: got i=%h pc=%h want 00000013 80000000", bus.inst, bus.inst_pc); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_req_stall();
    test_jump_wait();
    test_redirect_accept();
    test_priority();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 jump  input  1  branch/jump redirect request from IDU.
REQ-005 jump_addr  input  32  jump target.
REQ-006 csr_ecall  input  1  trap-entry redirect.
REQ-007 csr_mtvec  input  32  trap vector target.
REQ-008 csr_mret  input  1  trap-return redirect.
REQ-009 csr_mepc  input  32  trap return target.
REQ-010 imem_req_valid  output  1  fetch request to instruction memory.
REQ-011 imem_req_addr  output  32  fetch address.
REQ-012 imem_req_ready  input  1  memory accepts request.
REQ-013 imem_resp_valid  input  1  fetch data returned (one cycle pulse).
REQ-014 imem_resp_data  input  32  fetched instruction.
REQ-015 inst_valid  output  1  instruction available to IDU.
REQ-016 inst  output  32  instruction word.
REQ-017 inst_pc  output  32  PC of inst.
REQ-018 inst_ready  input  1  IDU consumes instruction.

Function
REQ-019 States IDLE, REQ, WAIT, VALID; pc register holds address of current fetch.
REQ-020 Redirect = jump | csr_ecall | csr_mret; target priority jump_addr > csr_mtvec > csr_mepc.
REQ-021 IDLE -> REQ unconditionally one cycle after rst deasserts; no outputs asserted in IDLE.
REQ-022 REQ: imem_req_valid=1, imem_req_addr=pc; on req_valid&req_ready -> WAIT.
REQ-023 REQ with redirect and no acceptance: pc <= target, stay REQ (addr may change before acceptance).
REQ-024 REQ with redirect and acceptance same cycle: set drop flag, pc <= target, -> WAIT.
REQ-025 WAIT: on resp_valid with drop=0, latch data into inst, inst_pc <= pc, -> VALID.
REQ-026 WAIT: on resp_valid with drop=1, discard data, clear drop, -> REQ (refetch at pc).
REQ-027 WAIT with redirect: drop <= 1, pc <= target; if resp_valid same cycle, discard data and -> REQ.
REQ-028 VALID: inst_valid=1, inst/inst_pc stable until inst_valid&inst_ready.
REQ-029 VALID handshake without redirect: pc <= inst_pc + 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0), -> REQ.
REQ-030 VALID with redirect (with or without handshake): pc <= target, inst_valid drops next cycle, -> REQ.
REQ-031 Minimum latency: request accepted cycle N, resp at N+1 -> inst_valid at N+2; at most one request outstanding.
REQ-032 imem_resp_valid outside WAIT is ignored.
REQ-033 Redirect in IDLE is ignored.

Reset
REQ-034 rst in any state, mid-transaction included: state IDLE, pc=RESET_PC, drop=0, inst=0, inst_pc=0, imem_req_valid=0, inst_valid=0 next cycle.
REQ-035 Response arriving after reset for a pre-reset request is ignored per REQ-032.

Structure
REQ-036 State encoding and RESET_PC default live in shared package core_pkg.
REQ-037 Redirect priority mux is one sub-module, redirect_sel (combinational, 3 requests -> valid + target).

Verification
REQ-038 Reset then req_ready=1, resp 1-cycle later, inst_ready=1: addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 delivered with matching inst_pc.
REQ-039 req_ready low 3 cycles: imem_req_valid held, addr stable 0x8000_0000, accepted on cycle 4.
REQ-040 jump=1, jump_addr=0x8000_0100 during WAIT: returned data discarded, next request 0x8000_0100, no inst_valid for old PC.
REQ-041 jump and csr_ecall together (mtvec=0x8000_0200) at VALID handshake: next fetch 0x8000_0100; ecall+mret only: 0x8000_0200.
REQ-042 inst_ready low 5 cycles in VALID: inst/inst_pc stable, no new request issued.
REQ-043 rst asserted in WAIT, resp_valid arrives next cycle: ignored; fetch restarts at 0x8000_0000.
